// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and FSM encoding shared by the UART transmitter.
package uart_pkg;
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CLEAR  = 4'h8;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;
    localparam int CLR_BIT  = 3;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(2**AW);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-bus mapped 8N1 transmitter with a byte FIFO and combinational STATUS readback.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_e           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d, ovf_q, ovf_d;
    logic [31:0]      off, status;
    logic [3:0]       reg_off;
    logic [FIFO_AW:0] count;
    logic [7:0]       head;
    logic             wr_txdata, wr_clear, pop, full, empty, tick, unused_bits;
    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    assign off         = addr - BASE_ADDR;
    assign sel         = off < 32'd12;
    assign reg_off     = {off[3:2], 2'b00};
    assign wr_txdata   = sel && we != 2'b00 && reg_off == OFF_TXDATA;
    assign wr_clear    = sel && we != 2'b00 && reg_off == OFF_CLEAR && wdata[CLR_BIT];
    assign pop         = state_q == IDLE && !empty;
    assign tick        = baud_q == CW'(CLKS_PER_BIT - 1);
    assign busy        = state_q != IDLE || !empty;
    assign tx          = tx_q;
    assign ovf_d       = wr_clear ? 1'b0 : (wr_txdata && full && !pop) ? 1'b1 : ovf_q;
    assign rdata       = (sel && reg_off == OFF_STATUS) ? status : '0;
    assign unused_bits = ^{wdata[31:8], off[1:0]};
    always_comb begin
        status                       = '0;
        status[ST_FULL]              = full;
        status[ST_EMPTY]             = empty;
        status[ST_BUSY]              = busy;
        status[ST_OVF]               = ovf_q;
        status[ST_COUNT +: FIFO_AW+1] = count;
    end
    uart_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_txdata),
        .pop_i   (pop),
        .data_i  (wdata[7:0]),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q == IDLE) begin
            if (pop) begin
                state_d = START;
                baud_d  = '0;
                shift_d = head;
            end
        end else begin
            baud_d = tick ? '0 : baud_q + 1'b1;
            if (tick) begin
                bit_d   = state_q == DATA ? bit_q + 1'b1 : 3'd0;
                shift_d = state_q == DATA ? shift_q >> 1 : shift_q;
                state_d = state_q == START ? DATA : state_q == STOP ? IDLE : &bit_q ? STOP : DATA;
            end
        end
    end
    // tx is registered, so it is derived from the state being entered.
    always_comb begin
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed and random stimulus checked against a frame-level reference model.
module tb_uart_tx_mmio;
    localparam int          CPB   = 4;
    localparam int          AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        sel, tx, busy;
    logic [31:0] rdata;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  q[$];
    int          el = -1;
    logic [7:0]  cur = 8'h0;
    logic        ovf = 1'b0;
    logic [9:0]  pat, pat2;
    always #5 clk = ~clk;
    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .sel   (sel),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );
    function automatic logic m_sel(input logic [31:0] a);
        return (a - BASE) < 32'd12;
    endfunction
    function automatic logic [1:0] m_word(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return d[1:0];
    endfunction
    function automatic logic [31:0] m_status();
        return (32'(q.size()) << 8) | ((el >= 0 || q.size() > 0) ? 32'd4 : 32'd0) |
               (ovf ? 32'd8 : 32'd0) | (q.size() == 0 ? 32'd2 : 32'd0) |
               (q.size() == DEPTH ? 32'd1 : 32'd0);
    endfunction
    function automatic logic m_tx();
        int b;
        if (el < 0) return 1'b1;
        b = el / CPB;
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : cur[b-1];
    endfunction
    function automatic logic [31:0] m_rdata();
        return (m_sel(addr) && m_word(addr) == 2'd1) ? m_status() : 32'd0;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        logic st, push, clr, pop;
        st   = we != 2'b00 && m_sel(addr);
        push = st && m_word(addr) == 2'd0;
        clr  = st && m_word(addr) == 2'd2 && wdata[3];
        @(posedge clk);
        if (reset) begin
            q.delete();
            el  = -1;
            ovf = 1'b0;
        end else begin
            pop = el < 0 && q.size() > 0;
            if (el >= 0) begin
                el++;
                if (el == 10 * CPB) el = -1;
            end
            if (pop) begin
                cur = q.pop_front();
                el  = 0;
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(wdata[7:0]);
                else ovf = 1'b1;
            end
            if (clr) ovf = 1'b0;
        end
        #1;
        check("tx", 32'(tx), 32'(m_tx()));
        check("busy", 32'(busy), 32'((el >= 0 || q.size() > 0) ? 1 : 0));
        check("sel", 32'(sel), 32'(m_sel(addr)));
        check("rdata", rdata, m_rdata());
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 2'b10;
        cyc();
        we    = 2'b00;
    endtask
    task automatic peek_status(input string tag, input logic [31:0] exp);
        addr = BASE + 32'h4;
        we   = 2'b00;
        #1;
        check(tag, rdata, exp);
    endtask
    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        addr  = BASE + 32'h4;
        #1;
        check("reset_status", rdata, 32'h0000_0002);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        // Single byte 0xA5
        pat = {1'b1, 8'hA5, 1'b0};
        store(BASE, 32'h0000_00A5);
        addr = BASE + 32'h4;
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("frame_a5", 32'(tx), 32'(pat[k/4]));
            check("busy_a5", 32'(busy), 32'd1);
        end
        cyc();
        check("busy_fall", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
        // Back-to-back 0x55 then 0x0F
        pat  = {1'b1, 8'h55, 1'b0};
        pat2 = {1'b1, 8'h0F, 1'b0};
        store(BASE, 32'h55);
        store(BASE + 32'h1, 32'h0F);
        check("b2b_start", 32'(tx), 32'd0);
        addr = BASE + 32'h4;
        for (int k = 1; k < 82; k++) begin
            cyc();
            if (k < 40) check("frame_55", 32'(tx), 32'(pat[k/4]));
            else if (k == 40) begin
                check("gap_tx", 32'(tx), 32'd1);
                check("gap_busy", 32'(busy), 32'd1);
            end else if (k < 81) check("frame_0f", 32'(tx), 32'(pat2[(k-41)/4]));
            else check("b2b_done", 32'(busy), 32'd0);
        end
        // Overflow: six rapid stores while the first frame holds the serializer
        for (int i = 0; i < 6; i++) store(BASE, 32'($urandom_range(0, 255)));
        peek_status("ovf_status", 32'h0000_040D);
        store(BASE + 32'h8, 32'h8);
        peek_status("ovf_clear", 32'h0000_0405);
        // Full FIFO: store coincides with the IDLE pop
        addr = BASE + 32'h4;
        for (int i = 0; i < 100 && el >= 0; i++) cyc();
        check("full_idle_tx", 32'(tx), 32'd1);
        store(BASE, 32'h3C);
        peek_status("full_pop", 32'h0000_0405);
        // Reset during DATA bit 3
        for (int i = 0; i < 100 && el != 17; i++) cyc();
        check("mid_frame_tx", 32'(tx), 32'(m_tx()));
        reset = 1'b1;
        cyc();
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_status", rdata, 32'h0000_0002);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            check("no_frame", 32'(tx), 32'd1);
        end
        // Random traffic including reserved offsets, out-of-window addresses and resets
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 8))
                0, 1, 2: addr = BASE + 32'($urandom_range(0, 3));
                3:       addr = BASE + 32'h4 + 32'($urandom_range(0, 3));
                4:       addr = BASE + 32'h8 + 32'($urandom_range(0, 3));
                5:       addr = BASE + 32'hC;
                6:       addr = BASE - 32'h1;
                default: addr = $urandom;
            endcase
            wdata = $urandom;
            we    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            reset = $urandom_range(0, 499) == 0;
            cyc();
        end
        reset = 1'b0;
        we    = 2'b00;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter consuming the core's data-memory store bus (address, write data, write enable).
- Stores to TXDATA push bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto the `tx` pin at a fixed baud.
- STATUS is readable combinationally so single-cycle loads to the peripheral complete in the same cycle.
- Sits beside the data memory; the top-level read mux selects `rdata` when the address hits BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 3-word register window.
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Legal minimum is 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- we  in  2  store enable, same encoding as MemWrite; any nonzero value is a store
- addr  in  32  byte address (ALUResult)
- wdata  in  32  store data; only [7:0] used for TXDATA
- sel  out  1  combinational; 1 when addr is in [BASE_ADDR, BASE_ADDR+0xB]
- rdata  out  32  combinational read data for addr; 0 when sel=0
- tx  out  1  serial output, registered, idles high
- busy  out  1  1 when FSM state is not IDLE or FIFO is non-empty

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 TXDATA: write-only; reads return 0.
  - 0x4 STATUS: read-only except the overflow clear.
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - bits[8+FIFO_AW:8] hold the FIFO count; all other bits read 0.
  - 0x8 CLEAR: a store with wdata[3]=1 clears overflow; reads return 0.
  - addr[1:0] is ignored. Stores to unmapped offsets inside the window are ignored.
- Reset values:
  - tx=1, busy=0, FIFO empty (count 0), overflow=0.
  - FSM in IDLE, baud counter 0, bit index 0.
  - Asserting reset mid-frame aborts the frame: tx=1 after the next edge and FIFO contents are discarded.
- Push: a store hitting TXDATA at edge E writes wdata[7:0] into the FIFO at E.
  - If the FIFO is full and no pop occurs at E, the byte is dropped and overflow is set.
  - If a push and a pop occur at the same edge while full, the push is accepted and count is unchanged.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO is non-empty, pop the head into the shift register at that edge and go to START with baud counter 0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). After CLKS_PER_BIT cycles, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - The baud counter counts 0..CLKS_PER_BIT-1; the state/bit advance occurs at the edge where counter = CLKS_PER_BIT-1, and the counter wraps to 0.
  - Latency: a store at edge E0 causes a pop at E1, and tx falls after E1. A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 idle cycle, spent in IDLE with tx=1.
  - FIFO pointers wrap modulo 2**FIFO_AW. Count ranges 0..2**FIFO_AW.

Decomposition:
- Package uart_pkg holds:
  - register offsets (TXDATA=0x0, STATUS=0x4, CLEAR=0x8)
  - STATUS bit indices
  - 2-bit FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3
- One sub-module, uart_fifo:
  - synchronous FIFO parameterised by width 8 and FIFO_AW
  - push/pop/full/empty/count interface
  - simultaneous push+pop when full is allowed
- Baud counter, FSM, and register decode live in uart_tx_mmio.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2, BASE_ADDR=0x400):
- Reset check: reset for 2 cycles, then read 0x404 -> tx=1, rdata=0x0000_0002 (empty), busy=0.
- Single byte: store 0x0000_00A5 to 0x400 at E0 -> tx low from E1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; busy falls 40 cycles after E1.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles -> two 40-cycle frames with exactly 1 idle-high cycle between them.
- Overflow: with the FSM frozen mid-frame, store 6 bytes rapidly. Expected:
  - the first byte is popped, 4 queue, the 6th is dropped
  - STATUS reads full=1, overflow=1, count=4
  - store 0x8 to 0x408 -> overflow=0
- Full-with-pop: FIFO full and the IDLE pop coincides with a TXDATA store -> byte accepted, count stays 4, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 after the next edge, STATUS=0x2, and no further frames are sent.
